waveform_stream_shaper: RTL and testbench

//  Streaming, parametrised waveform converter: accepts a frame of DEPTH quantised samples over a

---
 rtl/waveform_stream_shaper_pkg.sv | 17 +
 rtl/waveform_stream_shaper_if.sv | 22 ++
 rtl/waveform_stream_shaper_fm_toggle.sv | 54 +++++
 rtl/waveform_stream_shaper.sv | 156 +++++++++++++++
 tb/tb_waveform_stream_shaper.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/waveform_stream_shaper_pkg.sv
// Shared types for the waveform stream shaper: one-hot shaping modes and the frame FSM states.
package waveform_stream_shaper_pkg;

  typedef enum logic [3:0] {
    WM_PASS = 4'b0001,
    WM_TRI  = 4'b0010,
    WM_SQR  = 4'b0100,
    WM_FM   = 4'b1000
  } wave_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } wfs_state_e;

endpackage

// File: rtl/waveform_stream_shaper_if.sv
// Sample stream bundle for the shaper: input valid/ready channel and output valid/ready channel.
interface waveform_stream_shaper_if #(parameter int DATA_W = 8);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/waveform_stream_shaper_fm_toggle.sv
// FM toggle state: half-period counter and output bit, with the half-period derived from the sample.
module waveform_stream_shaper_fm_toggle #(
  parameter int DATA_W      = 8,
  parameter int FM_MAX_STEP = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              fm_bit_next_o
);

  localparam int MAXV = 2**DATA_W - 1;
  localparam int SW   = $clog2(FM_MAX_STEP + 1);
  localparam int XMAX = MAXV * (FM_MAX_STEP - 1);
  localparam int SH   = $clog2(MAXV) + $clog2(XMAX + 1);
  // Division by MAXV as multiply-by-reciprocal; 2**SH > MAXV*XMAX keeps the floor exact over the range.
  localparam logic [63:0] RECIP = ((64'd1 << SH) + 64'(MAXV) - 64'd1) / 64'(MAXV);

  logic [SW-1:0] step;
  logic [SW-1:0] pos_inc;
  logic [SW-1:0] fm_pos_q, fm_pos_d;
  logic          fm_bit_q, fm_bit_d;
  logic          toggle;

  assign step          = SW'(1) + SW'((64'(sample_i) * 64'(FM_MAX_STEP - 1) * RECIP) >> SH);
  assign pos_inc       = fm_pos_q + SW'(1);
  assign toggle        = (pos_inc >= step);
  assign fm_bit_next_o = toggle ? ~fm_bit_q : fm_bit_q;

  always_comb begin
    fm_pos_d = fm_pos_q;
    fm_bit_d = fm_bit_q;
    if (clr_i) begin
      fm_pos_d = '0;
      fm_bit_d = 1'b0;
    end else if (adv_i) begin
      fm_pos_d = toggle ? '0 : pos_inc;
      fm_bit_d = fm_bit_next_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_pos_q <= '0;
      fm_bit_q <= 1'b0;
    end else begin
      fm_pos_q <= fm_pos_d;
      fm_bit_q <= fm_bit_d;
    end
  end

endmodule

// File: rtl/waveform_stream_shaper.sv
// Frame-based waveform shaper (pass/triangle/square/FM) with a one-deep backpressurable output stage.
// Optional WFS_ABORT_EN adds abort_i, which drops an in-flight frame without frame_done.
module waveform_stream_shaper
  import waveform_stream_shaper_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int FM_MAX_STEP = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             mode_i,
  input  logic                   start_i,
`ifdef WFS_ABORT_EN
  input  logic                   abort_i,
`endif
  waveform_stream_shaper_if.slave bus,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int MAXV  = 2**DATA_W - 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TRI_W = IDX_W + DATA_W;

  wfs_state_e         state_q, state_d;
  logic [3:0]         mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               frame_done_q, frame_done_d;

  logic               in_ready;
  logic               in_hs;
  logic               out_hs;
  logic               abort_w;
  logic               idx_last;
  logic               fm_clr;
  logic               fm_adv;
  logic               fm_bit_next;
  logic [IDX_W-2:0]   tri_t;
  logic [TRI_W-1:0]   tri_w;
  logic [DATA_W-1:0]  tri_val;
  logic [DATA_W-1:0]  shaped;

`ifdef WFS_ABORT_EN
  assign abort_w = abort_i && (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready) && !abort_w;
  assign in_hs    = bus.in_valid && in_ready;
  assign out_hs   = out_valid_q && bus.out_ready;
  assign idx_last = (idx_q == IDX_W'(DEPTH - 1));
  assign fm_clr   = ((state_q == S_IDLE) && start_i) || abort_w;
  assign fm_adv   = in_hs && (mode_q == WM_FM);

  // Falling half mirrors the rising half: DEPTH-1-k equals the complement of k's low bits.
  assign tri_t   = idx_q[IDX_W-1] ? ~idx_q[IDX_W-2:0] : idx_q[IDX_W-2:0];
  assign tri_w   = {tri_t, {(DATA_W + 1){1'b0}}} >> IDX_W;
  assign tri_val = (tri_w > TRI_W'(MAXV)) ? DATA_W'(MAXV) : tri_w[DATA_W-1:0];

  always_comb begin
    shaped = '0;
    case (mode_q)
      WM_PASS: shaped = bus.in_data;
      WM_TRI:  shaped = tri_val;
      WM_SQR:  shaped = bus.in_data[DATA_W-1] ? DATA_W'(MAXV) : '0;
      WM_FM:   shaped = fm_bit_next ? DATA_W'(MAXV) : '0;
      default: shaped = '0;
    endcase
  end

  waveform_stream_shaper_fm_toggle #(
    .DATA_W      (DATA_W),
    .FM_MAX_STEP (FM_MAX_STEP)
  ) u_fm (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (fm_clr),
    .adv_i         (fm_adv),
    .sample_i      (bus.in_data),
    .fm_bit_next_o (fm_bit_next)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    out_valid_d  = out_valid_q && !out_hs;
    out_last_d   = out_last_q && !out_hs;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          mode_d  = mode_i;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (in_hs) begin
          out_valid_d = 1'b1;
          out_data_d  = shaped;
          out_last_d  = idx_last;
          if (idx_last) state_d = S_DRAIN;
          else          idx_d   = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_hs && out_last_q) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_w) begin
      state_d      = S_IDLE;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy_o        = (state_q != S_IDLE);
  assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_waveform_stream_shaper.sv
// Bench for waveform_stream_shaper: frame-level reference model with a per-cycle compare process.
module tb_waveform_stream_shaper;
  import waveform_stream_shaper_pkg::*;

  localparam int DATA_W      = 8;
  localparam int DEPTH       = 256;
  localparam int FM_MAX_STEP = 20;
  localparam int MAXV        = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mode_i;
  logic       start_i;
  logic       busy_o;
  logic       frame_done_o;
`ifdef WFS_ABORT_EN
  logic       abort_i;
`endif

  waveform_stream_shaper_if #(.DATA_W(DATA_W)) bus ();

  waveform_stream_shaper #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .FM_MAX_STEP(FM_MAX_STEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode_i       (mode_i),
    .start_i      (start_i),
`ifdef WFS_ABORT_EN
    .abort_i      (abort_i),
`endif
    .bus          (bus),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: what the frame must look like from the outside.
  bit mActive = 0;
  bit mDonePend = 0;
  int mMode = 0;
  int mAcc = 0;
  int mCons = 0;
  int fmPos = 0;
  bit fmBit = 0;
  int qData[$];
  bit qLast[$];
  int cap[DEPTH];
  int doneSeen = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int triExpect(int k);
    int t, v;
    t = (k < DEPTH / 2) ? k : DEPTH - 1 - k;
    v = (t * 2 * (MAXV + 1)) / DEPTH;
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic int fmStep(int d);
    return 1 + (d * (FM_MAX_STEP - 1)) / MAXV;
  endfunction

  function automatic int patData(int pat, int k);
    case (pat)
      0: return k % 256;
      1: return int'($urandom_range(255));
      2: return 255;
      3: return 0;
      default: begin
        case (k % 4)
          0: return 127;
          1: return 128;
          2: return 0;
          default: return 255;
        endcase
      end
    endcase
  endfunction

  // Compare process: check the outputs against the model, then advance the model for the coming edge.
  always @(negedge clk) begin : cmp
    bit wasActive, expReady, abortNow;
    int e, p, d;
    if (rst) begin
      mActive = 0; mDonePend = 0;
      qData.delete(); qLast.delete();
    end else begin
      abortNow = 0;
`ifdef WFS_ABORT_EN
      abortNow = abort_i && mActive;
`endif
      expReady = mActive && (mAcc < DEPTH) && (!bus.out_valid || bus.out_ready) && !abortNow;
      checkOutput("busy", 32'(busy_o), 32'(mActive));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(qData.size() != 0));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
      checkOutput("frame_done", 32'(frame_done_o), 32'(mDonePend));
      if (bus.out_valid && qData.size() != 0) begin
        checkOutput("out_data", 32'(bus.out_data), 32'(qData[0]));
        checkOutput("out_last", 32'(bus.out_last), 32'(qLast[0]));
      end
      if (frame_done_o) doneSeen++;
      mDonePend = 0;
      wasActive = mActive;
      if (abortNow) begin
        mActive = 0;
        qData.delete(); qLast.delete();
      end else begin
        if (bus.out_valid && bus.out_ready && qData.size() != 0) begin
          cap[mCons] = int'(bus.out_data);
          void'(qData.pop_front());
          void'(qLast.pop_front());
          mCons++;
          if (mCons == DEPTH) begin
            mActive = 0;
            mDonePend = 1;
          end
        end
        if (bus.in_valid && bus.in_ready && wasActive && mAcc < DEPTH) begin
          d = int'(bus.in_data);
          case (mMode)
            1: e = d;
            2: e = triExpect(mAcc);
            4: e = (d >= 128) ? MAXV : 0;
            8: begin
              p = fmPos + 1;
              if (p >= fmStep(d)) begin fmBit = !fmBit; fmPos = 0; end
              else fmPos = p;
              e = fmBit ? MAXV : 0;
            end
            default: e = 0;
          endcase
          qData.push_back(e);
          qLast.push_back(mAcc == DEPTH - 1);
          mAcc++;
        end
        if (start_i && !wasActive) begin
          mActive = 1; mMode = int'(mode_i);
          mAcc = 0; mCons = 0; fmPos = 0; fmBit = 0;
          foreach (cap[i]) cap[i] = -1;
        end
      end
    end
  end

  // Runs one frame; stopKind 1 asserts reset, 2 asserts abort, once stopAt samples were accepted.
  task automatic applyStimulus(input logic [3:0] m, input int pat, input int bp,
                               input int stopAt, input int stopKind);
    int sent, cyc, doneBefore;
    bit hs;
    doneBefore = doneSeen;
    @(posedge clk); #1;
    mode_i = m; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    sent = 0; cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_data = DATA_W'(patData(pat, 0));
    bus.out_ready = 1'b1;
    while (doneSeen == doneBefore && cyc < 4000) begin
      if (stopKind != 0 && sent == stopAt) break;
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        sent++;
        bus.in_data = DATA_W'(patData(pat, sent));
      end
      bus.in_valid = (sent < DEPTH) && (bp == 0 || $urandom_range(3) != 0);
      bus.out_ready = (bp == 0) || ($urandom_range(1) == 1);
      if (bp != 0) mode_i = 4'($urandom_range(15));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (cyc >= 4000) begin
      nCompared++; nMismatched++;
      $display("[TB] FAIL frame_timeout: got no frame_done, expected one within 4000 cycles");
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    end else if (stopKind == 1) begin
      rst = 1'b1;
      #1;
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
      checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end
`ifdef WFS_ABORT_EN
    else if (stopKind == 2) begin
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      checkOutput("abort_busy", 32'(busy_o), 32'd0);
      checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("abort_no_done", 32'(doneSeen), 32'(doneBefore));
    end
`endif
  endtask

  initial begin
    int frames;
    rst = 1'b1; mode_i = '0; start_i = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
`ifdef WFS_ABORT_EN
    abort_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done_o), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;

    checkOutput("model_tri_1", 32'(triExpect(1)), 32'd2);
    checkOutput("model_tri_128", 32'(triExpect(128)), 32'd254);
    checkOutput("model_fm_step_255", 32'(fmStep(255)), 32'd20);
    checkOutput("model_fm_step_128", 32'(fmStep(128)), 32'd10);

    frames = 0;
    applyStimulus(WM_PASS, 0, 0, 0, 0); frames++;
    checkOutput("pass_0", 32'(cap[0]), 32'd0);
    checkOutput("pass_200", 32'(cap[200]), 32'd200);
    checkOutput("pass_255", 32'(cap[255]), 32'd255);

    applyStimulus(WM_TRI, 1, 0, 0, 0); frames++;
    checkOutput("tri_0", 32'(cap[0]), 32'd0);
    checkOutput("tri_1", 32'(cap[1]), 32'd2);
    checkOutput("tri_127", 32'(cap[127]), 32'd254);
    checkOutput("tri_128", 32'(cap[128]), 32'd254);
    checkOutput("tri_255", 32'(cap[255]), 32'd0);

    applyStimulus(WM_SQR, 4, 0, 0, 0); frames++;
    checkOutput("sqr_127", 32'(cap[0]), 32'd0);
    checkOutput("sqr_128", 32'(cap[1]), 32'd255);
    checkOutput("sqr_0", 32'(cap[2]), 32'd0);
    checkOutput("sqr_255", 32'(cap[3]), 32'd255);

    applyStimulus(WM_FM, 2, 0, 0, 0); frames++;
    checkOutput("fm255_18", 32'(cap[18]), 32'd0);
    checkOutput("fm255_19", 32'(cap[19]), 32'd255);
    checkOutput("fm255_38", 32'(cap[38]), 32'd255);
    checkOutput("fm255_39", 32'(cap[39]), 32'd0);

    applyStimulus(WM_FM, 3, 0, 0, 0); frames++;
    checkOutput("fm0_0", 32'(cap[0]), 32'd255);
    checkOutput("fm0_1", 32'(cap[1]), 32'd0);
    checkOutput("fm0_2", 32'(cap[2]), 32'd255);

    applyStimulus(WM_PASS, 1, 1, 0, 0); frames++;
    applyStimulus(WM_TRI, 1, 1, 0, 0); frames++;
    applyStimulus(WM_FM, 1, 1, 0, 0); frames++;
    applyStimulus(4'b0011, 1, 0, 0, 0); frames++;
    checkOutput("invalid_mode_10", 32'(cap[10]), 32'd0);
    checkOutput("frames_before_reset", 32'(doneSeen), 32'(frames));

    applyStimulus(WM_PASS, 0, 0, 100, 1);
    applyStimulus(WM_PASS, 0, 0, 0, 0); frames++;
    checkOutput("after_reset_255", 32'(cap[255]), 32'd255);
`ifdef WFS_ABORT_EN
    applyStimulus(WM_SQR, 1, 0, 50, 2);
    applyStimulus(WM_PASS, 0, 0, 0, 0); frames++;
`endif
    checkOutput("frame_count", 32'(doneSeen), 32'(frames));

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
